// File: rtl/wishbone_bus_if.sv
// Bridges a single-cycle CPU memory request onto a Wishbone B3 classic bus, stalling the pipeline until ack.
// Optional bus timeout abort: define WB_TIMEOUT_EN.
module wishbone_bus_if #(
    parameter int STALL_BIT      = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_ack_i,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_sel_o,
    output logic        wishbone_stb_o,
    output logic        wishbone_cyc_o,
    output logic        bus_err_o
);
    typedef enum logic [1:0] {IDLE, BUSY, WAIT_FOR_STALL} state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdat_q, wdat_d, rd_buf_q, rd_buf_d;
    logic        we_q, we_d, stb_q, stb_d, cyc_q, cyc_d;
    logic [3:0]  sel_q, sel_d;
    logic        timeout_hit;
    logic        stalled;
    logic        unused_cfg;

    assign stalled    = stall_i[STALL_BIT];
    assign unused_cfg = ^{stall_i, TO_LAST};

`ifdef WB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    assign timeout_hit = (cnt_q == TO_LAST);
    assign bus_err_o   = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err_o   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        we_d       = we_q;
        sel_d      = sel_q;
        stb_d      = stb_q;
        cyc_d      = cyc_q;
        rd_buf_d   = rd_buf_q;
        stallreq   = 1'b0;
        cpu_data_o = 32'h0;
`ifdef WB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                stallreq = cpu_ce_i && !flush_i;
                if (cpu_ce_i && !flush_i) begin
                    addr_d  = cpu_addr_i;
                    wdat_d  = cpu_data_i;
                    we_d    = cpu_we_i;
                    sel_d   = cpu_sel_i;
                    stb_d   = 1'b1;
                    cyc_d   = 1'b1;
                    state_d = BUSY;
`ifdef WB_TIMEOUT_EN
                    cnt_d   = 8'h0;
`endif
                end
            end
            BUSY: begin
                if (flush_i || wishbone_ack_i || timeout_hit) begin
                    addr_d = 32'h0;
                    wdat_d = 32'h0;
                    we_d   = 1'b0;
                    sel_d  = 4'h0;
                    stb_d  = 1'b0;
                    cyc_d  = 1'b0;
                end
                if (flush_i) begin
                    rd_buf_d = 32'h0;
                    state_d  = IDLE;
                end else if (wishbone_ack_i) begin
                    if (!we_q) begin
                        rd_buf_d   = wishbone_data_i;
                        cpu_data_o = wishbone_data_i;
                    end
                    state_d = stalled ? WAIT_FOR_STALL : IDLE;
                end else if (timeout_hit) begin
                    // Abort looks like a read returning zero, flagged on bus_err_o.
                    rd_buf_d = 32'h0;
                    state_d  = stalled ? WAIT_FOR_STALL : IDLE;
`ifdef WB_TIMEOUT_EN
                    err_d    = 1'b1;
`endif
                end else begin
                    stallreq = 1'b1;
`ifdef WB_TIMEOUT_EN
                    cnt_d    = cnt_q + 8'h1;
`endif
                end
            end
            WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf_q;
                if (flush_i) begin
                    rd_buf_d = 32'h0;
                    state_d  = IDLE;
                end else if (!stalled) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            wdat_q   <= 32'h0;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            rd_buf_q <= rd_buf_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'h0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    assign wishbone_addr_o = addr_q;
    assign wishbone_data_o = wdat_q;
    assign wishbone_we_o   = we_q;
    assign wishbone_sel_o  = sel_q;
    assign wishbone_stb_o  = stb_q;
    assign wishbone_cyc_o  = cyc_q;
endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if: transaction-level model checked every cycle plus literal spot checks.
module tb_wishbone_bus_if;
    localparam int SB = 1;
    localparam int TO = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic [5:0]  stall_i = '0;
    logic        flush_i = 1'b0, cpu_ce_i = 1'b0, cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, cpu_data_i = '0, wishbone_data_i = '0;
    logic [3:0]  cpu_sel_i = '0;
    logic        wishbone_ack_i = 1'b0;
    logic [31:0] cpu_data_o, wishbone_addr_o, wishbone_data_o;
    logic        stallreq, wishbone_we_o, wishbone_stb_o, wishbone_cyc_o, bus_err_o;
    logic [3:0]  wishbone_sel_o;

    int errors = 0, checks = 0;
    bit chk_en = 0;

    wishbone_bus_if #(.STALL_BIT(SB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
        .stallreq(stallreq), .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
        .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
        .wishbone_we_o(wishbone_we_o), .wishbone_sel_o(wishbone_sel_o),
        .wishbone_stb_o(wishbone_stb_o), .wishbone_cyc_o(wishbone_cyc_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    // Model: an outstanding request record, a held-read flag and the read buffer.
    bit          m_act = 0, m_hold = 0, m_err = 0, m_we = 0;
    logic [31:0] m_addr = '0, m_wdat = '0, m_rdbuf = '0;
    logic [3:0]  m_sel = '0;
    int          m_wait = 0;

    function automatic bit m_timeout();
`ifdef WB_TIMEOUT_EN
        return m_act && (m_wait == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        bit to;
        to = m_timeout();
        m_err = 0;
        if (rst) begin
            m_act = 0; m_hold = 0; m_rdbuf = '0;
        end else if (m_act) begin
            if (flush_i) begin
                m_act = 0; m_rdbuf = '0;
            end else if (wishbone_ack_i) begin
                m_act = 0;
                if (!m_we) m_rdbuf = wishbone_data_i;
                m_hold = stall_i[SB];
            end else if (to) begin
                m_act = 0; m_rdbuf = '0; m_hold = stall_i[SB]; m_err = 1;
            end else begin
                m_wait++;
            end
        end else if (m_hold) begin
            if (flush_i) begin
                m_hold = 0; m_rdbuf = '0;
            end else if (!stall_i[SB]) begin
                m_hold = 0;
            end
        end else if (cpu_ce_i && !flush_i) begin
            m_act = 1; m_wait = 0;
            m_addr = cpu_addr_i; m_wdat = cpu_data_i; m_we = cpu_we_i; m_sel = cpu_sel_i;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_sr;
            logic [31:0] e_dat;
            if (m_act) begin
                e_sr  = !(flush_i || wishbone_ack_i || m_timeout());
                e_dat = (!flush_i && wishbone_ack_i && !m_we) ? wishbone_data_i : 32'h0;
            end else if (m_hold) begin
                e_sr  = 1'b0;
                e_dat = m_rdbuf;
            end else begin
                e_sr  = cpu_ce_i && !flush_i;
                e_dat = 32'h0;
            end
            chk("cyc", 32'(wishbone_cyc_o), 32'(m_act));
            chk("stb", 32'(wishbone_stb_o), 32'(m_act));
            chk("addr", wishbone_addr_o, m_act ? m_addr : 32'h0);
            chk("wdata", wishbone_data_o, m_act ? m_wdat : 32'h0);
            chk("we", 32'(wishbone_we_o), 32'(m_act && m_we));
            chk("sel", 32'(wishbone_sel_o), m_act ? 32'(m_sel) : 32'h0);
            chk("stallreq", 32'(stallreq), 32'(e_sr));
            chk("cpu_data", cpu_data_o, e_dat);
            chk("bus_err", 32'(bus_err_o), 32'(m_err));
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        int sr, wec, hold, cy, ec;
        nxt(); nxt();
        chk_en = 1;
        neg();
        chk("rst_cyc", 32'(wishbone_cyc_o), 32'h0);
        chk("rst_addr", wishbone_addr_o, 32'h0);
        chk("rst_err", 32'(bus_err_o), 32'h0);
        nxt(); rst = 0;

        // Zero-wait read
        cpu_ce_i = 1; cpu_addr_i = 32'h10; cpu_we_i = 0; cpu_sel_i = 4'hF; cpu_data_i = 32'h0;
        neg(); chk("t1_sr_idle", 32'(stallreq), 32'h1);
        nxt(); cpu_ce_i = 0; wishbone_ack_i = 1; wishbone_data_i = 32'h1234_5678;
        neg();
        chk("t1_cyc", 32'(wishbone_cyc_o), 32'h1);
        chk("t1_addr", wishbone_addr_o, 32'h10);
        chk("t1_sr_ack", 32'(stallreq), 32'h0);
        chk("t1_data", cpu_data_o, 32'h1234_5678);
        nxt(); wishbone_ack_i = 0;
        neg(); chk("t1_cyc_drop", 32'(wishbone_cyc_o), 32'h0);
        nxt();

        // Write, 3 wait states
        cpu_ce_i = 1; cpu_we_i = 1; cpu_sel_i = 4'b0011; cpu_data_i = 32'hDEAD_BEEF; cpu_addr_i = 32'h20;
        sr = 0; wec = 0;
        for (int i = 0; i < 5; i++) begin
            wishbone_ack_i = (i == 4);
            neg();
            sr  += int'(stallreq);
            wec += int'(wishbone_we_o && wishbone_sel_o == 4'b0011);
            if (i == 4) chk("t2_data", cpu_data_o, 32'h0);
            nxt(); cpu_ce_i = 0;
        end
        wishbone_ack_i = 0; cpu_we_i = 0;
        chk("t2_sr_cycles", 32'(sr), 32'd4);
        chk("t2_we_cycles", 32'(wec), 32'd4);

        // Read ack while stalled, held in WAIT_FOR_STALL
        cpu_ce_i = 1; cpu_addr_i = 32'h30; cpu_sel_i = 4'hF;
        nxt(); cpu_ce_i = 0; wishbone_ack_i = 1; wishbone_data_i = 32'hCAFE_F00D; stall_i[SB] = 1;
        neg(); chk("t3_ack_data", cpu_data_o, 32'hCAFE_F00D);
        nxt(); wishbone_ack_i = 0; wishbone_data_i = 32'h0;
        hold = 0;
        for (int i = 0; i < 3; i++) begin
            stall_i[SB] = (i < 2);
            neg();
            hold += int'(cpu_data_o == 32'hCAFE_F00D && !stallreq);
            nxt();
        end
        chk("t3_hold_cycles", 32'(hold), 32'd3);
        neg(); chk("t3_idle_data", cpu_data_o, 32'h0);
        nxt();

        // Flush in second BUSY cycle with same-cycle ack
        cpu_ce_i = 1; cpu_addr_i = 32'h40;
        nxt(); cpu_ce_i = 0;
        nxt(); wishbone_ack_i = 1; flush_i = 1; wishbone_data_i = 32'h55;
        neg(); chk("t4_sr", 32'(stallreq), 32'h0); chk("t4_data", cpu_data_o, 32'h0);
        nxt(); wishbone_ack_i = 0; flush_i = 0;
        neg(); chk("t4_cyc", 32'(wishbone_cyc_o), 32'h0);
        // A stalled write ack exposes rd_buf, which the flush must have cleared
        cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h44;
        nxt(); cpu_ce_i = 0; wishbone_ack_i = 1; stall_i[SB] = 1;
        nxt(); wishbone_ack_i = 0; cpu_we_i = 0;
        neg(); chk("t4_rdbuf_clr", cpu_data_o, 32'h0);
        nxt(); stall_i[SB] = 0;
        nxt();
        // Flush while holding read data
        cpu_ce_i = 1; cpu_addr_i = 32'h48;
        nxt(); cpu_ce_i = 0; wishbone_ack_i = 1; wishbone_data_i = 32'hA5A5_A5A5; stall_i[SB] = 1;
        nxt(); wishbone_ack_i = 0; flush_i = 1;
        neg(); chk("t4_wfs_data", cpu_data_o, 32'hA5A5_A5A5);
        nxt(); flush_i = 0;
        neg(); chk("t4_wfs_flush", cpu_data_o, 32'h0);
        nxt(); stall_i[SB] = 0;
        // Flush in IDLE blocks the request
        cpu_ce_i = 1; flush_i = 1;
        neg(); chk("t4_idle_flush_sr", 32'(stallreq), 32'h0);
        nxt(); cpu_ce_i = 0; flush_i = 0;
        neg(); chk("t4_idle_flush_cyc", 32'(wishbone_cyc_o), 32'h0);
        nxt();

        // Reset mid-transaction, then a late ack
        cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h50; cpu_data_i = 32'h11; cpu_sel_i = 4'hF;
        nxt(); cpu_ce_i = 0; rst = 1;
        neg(); chk("t5_busy_cyc", 32'(wishbone_cyc_o), 32'h1);
        nxt(); rst = 0; wishbone_ack_i = 1; wishbone_data_i = 32'h99; cpu_we_i = 0;
        neg();
        chk("t5_cyc", 32'(wishbone_cyc_o), 32'h0);
        chk("t5_addr", wishbone_addr_o, 32'h0);
        chk("t5_we", 32'(wishbone_we_o), 32'h0);
        chk("t5_data", cpu_data_o, 32'h0);
        nxt(); wishbone_ack_i = 0;

        // Back-to-back requests with an always-acking slave
        cpu_ce_i = 1; cpu_addr_i = 32'h60; wishbone_ack_i = 1; cy = 0;
        for (int i = 0; i < 6; i++) begin
            wishbone_data_i = 32'h100 + 32'(i);
            neg(); cy += int'(wishbone_cyc_o);
            nxt();
        end
        cpu_ce_i = 0; wishbone_ack_i = 0;
        chk("t6_cyc_cycles", 32'(cy), 32'd3);
        nxt();

        // Slave never acks
        cpu_ce_i = 1; cpu_addr_i = 32'h70; sr = 0; ec = 0;
`ifdef WB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            neg(); sr += int'(stallreq); ec += int'(bus_err_o);
            nxt(); cpu_ce_i = 0;
        end
        chk("t7_sr_cycles", 32'(sr), 32'd4);
        chk("t7_err_pulses", 32'(ec), 32'd1);
        neg(); chk("t7_cyc", 32'(wishbone_cyc_o), 32'h0);
`else
        nxt(); cpu_ce_i = 0;
        for (int i = 0; i < 100; i++) begin
            neg(); sr += int'(stallreq); ec += int'(bus_err_o);
            nxt();
        end
        chk("t7_sr_cycles", 32'(sr), 32'd100);
        chk("t7_err_cycles", 32'(ec), 32'd0);
        rst = 1; nxt(); rst = 0;
`endif
        nxt();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
